// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_BITS data bits LSB first, parity, stop(1).
// Delivers each received word with parity/framing status as a one-cycle valid pulse.
module parity_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | line watch; arms on a high sample, starts on a low one once armed
  // START  | wait to mid start bit and confirm it is still low
  // DATA   | one sample per bit period into the shift register
  // PARITY | capture the parity bit
  // STOP   | sample the stop bit and publish word plus flags
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 par_exp;

  assign par_exp = (ODD_PARITY != 0) ? ~^shift_reg : ^shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      armed      <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // glitch shorter than half a bit: drop it silently
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_TC) begin
            cnt       <= '0;
            shift_reg <= (shift_reg >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
            if (bit_idx == IDX_LAST) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_TC) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_TC) begin
            cnt        <= '0;
            data_out   <= shift_reg;
            parity_err <= (par_bit != par_exp);
            frame_err  <= ~rx_s;
            valid      <= 1'b1;
            armed      <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
